// File: rtl/i2c_master_xfer_seq_if.sv
// Request, streaming-data and byte-controller signals of the I2C register-transaction sequencer.
// The master modport is the sequencer's view; slave is the view of the surrounding logic.
interface i2c_master_xfer_seq_if #(parameter int LEN_W = 4);
  logic             req;
  logic             rnw;
  logic [6:0]       dev_addr;
  logic [7:0]       reg_addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic             bc_start;
  logic             bc_stop;
  logic             bc_read;
  logic             bc_write;
  logic             bc_ack_in;
  logic [7:0]       bc_din;
  logic             bc_cmd_ack;
  logic             bc_ack_out;
  logic [7:0]       bc_dout;

  modport master (
    input  req, rnw, dev_addr, reg_addr, len, wr_data, wr_valid,
    input  bc_cmd_ack, bc_ack_out, bc_dout,
    output wr_ready, rd_data, rd_valid, busy, done, err,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );

  modport slave (
    output req, rnw, dev_addr, reg_addr, len, wr_data, wr_valid,
    output bc_cmd_ack, bc_ack_out, bc_dout,
    input  wr_ready, rd_data, rd_valid, busy, done, err,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
endinterface

// File: rtl/i2c_master_xfer_seq.sv
// Register-transaction sequencer: turns one request into START/WRITE/READ/STOP byte commands.
// All outputs are registered; a command is held until the edge that samples bc_cmd_ack.
module i2c_master_xfer_seq #(
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  rst,
  i2c_master_xfer_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_REG, S_RSTA, S_WWAIT, S_WR, S_RD, S_ABORT
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_TWO = LEN_W'(2);

  state_t           r_state, w_state;
  logic             r_rnw, w_rnw;
  logic [6:0]       r_dev, w_dev;
  logic [7:0]       r_reg, w_reg;
  logic [LEN_W-1:0] r_cnt, w_cnt;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             r_wr_ready, w_wr_ready;
  logic             r_rd_valid, w_rd_valid;
  logic [7:0]       r_rd_data, w_rd_data;
  logic             r_start, w_start;
  logic             r_stop, w_stop;
  logic             r_read, w_read;
  logic             r_write, w_write;
  logic             r_ack_in, w_ack_in;
  logic [7:0]       r_din, w_din;

  logic w_ack, w_nack, w_cnt_one, w_cnt_two;
  assign w_ack     = bus.bc_cmd_ack;
  assign w_nack    = bus.bc_ack_out;
  assign w_cnt_one = (r_cnt == CNT_ONE);
  assign w_cnt_two = (r_cnt == CNT_TWO);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;  r_rnw <= 1'b0;  r_dev <= '0;  r_reg <= '0;  r_cnt <= '0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_err <= 1'b0;
      r_wr_ready <= 1'b0;  r_rd_valid <= 1'b0;  r_rd_data <= '0;
      r_start <= 1'b0;  r_stop <= 1'b0;  r_read <= 1'b0;  r_write <= 1'b0;
      r_ack_in <= 1'b0;  r_din <= '0;
    end else if (rst) begin
      r_state <= S_IDLE;  r_rnw <= 1'b0;  r_dev <= '0;  r_reg <= '0;  r_cnt <= '0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_err <= 1'b0;
      r_wr_ready <= 1'b0;  r_rd_valid <= 1'b0;  r_rd_data <= '0;
      r_start <= 1'b0;  r_stop <= 1'b0;  r_read <= 1'b0;  r_write <= 1'b0;
      r_ack_in <= 1'b0;  r_din <= '0;
    end else begin
      r_state <= w_state;  r_rnw <= w_rnw;  r_dev <= w_dev;  r_reg <= w_reg;  r_cnt <= w_cnt;
      r_busy <= w_busy;  r_done <= w_done;  r_err <= w_err;
      r_wr_ready <= w_wr_ready;  r_rd_valid <= w_rd_valid;  r_rd_data <= w_rd_data;
      r_start <= w_start;  r_stop <= w_stop;  r_read <= w_read;  r_write <= w_write;
      r_ack_in <= w_ack_in;  r_din <= w_din;
    end
  end

  always_comb begin
    w_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.req) w_state = S_DEV;
      S_DEV:   if (w_ack) w_state = w_nack ? S_ABORT : S_REG;
      S_REG:   if (w_ack) begin
                 if (r_stop)      w_state = S_IDLE;
                 else if (w_nack) w_state = S_ABORT;
                 else if (r_rnw)  w_state = S_RSTA;
                 else             w_state = S_WWAIT;
               end
      S_WWAIT: if (bus.wr_valid) w_state = S_WR;
      S_WR:    if (w_ack) begin
                 if (r_stop)      w_state = S_IDLE;
                 else if (w_nack) w_state = S_ABORT;
                 else             w_state = S_WWAIT;
               end
      S_RSTA:  if (w_ack) w_state = w_nack ? S_ABORT : S_RD;
      S_RD:    if (w_ack && w_cnt_one) w_state = S_IDLE;
      S_ABORT: if (w_ack) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rnw = r_rnw;  w_dev = r_dev;  w_reg = r_reg;  w_cnt = r_cnt;
    w_busy = r_busy;  w_err = r_err;  w_done = 1'b0;
    w_wr_ready = 1'b0;  w_rd_valid = 1'b0;  w_rd_data = r_rd_data;
    w_start = r_start;  w_stop = r_stop;  w_read = r_read;  w_write = r_write;
    w_ack_in = r_ack_in;  w_din = r_din;

    // An acknowledged command is always dropped; the case below may load its successor.
    if (r_state != S_IDLE && w_ack) begin
      w_start = 1'b0;  w_stop = 1'b0;  w_read = 1'b0;  w_write = 1'b0;
      w_ack_in = 1'b0;  w_din = '0;
    end

    case (r_state)
      S_IDLE: if (bus.req) begin
        w_rnw = bus.rnw;  w_dev = bus.dev_addr;  w_reg = bus.reg_addr;  w_cnt = bus.len;
        w_busy = 1'b1;  w_err = 1'b0;
        w_start = 1'b1;  w_write = 1'b1;  w_din = {bus.dev_addr, 1'b0};
      end
      S_DEV: if (w_ack) begin
        if (w_nack) begin
          w_stop = 1'b1;  w_err = 1'b1;
        end else begin
          w_write = 1'b1;  w_din = r_reg;  w_stop = (r_cnt == '0);
        end
      end
      S_REG, S_WR: if (w_ack) begin
        if (r_stop) begin
          // The byte controller already sent STOP after a NACKed last byte.
          w_busy = 1'b0;  w_done = 1'b1;  w_err = r_err | w_nack;
        end else if (w_nack) begin
          w_stop = 1'b1;  w_err = 1'b1;
        end else if (r_state == S_REG && r_rnw) begin
          w_start = 1'b1;  w_write = 1'b1;  w_din = {r_dev, 1'b1};
        end
      end
      S_WWAIT: if (bus.wr_valid) begin
        w_wr_ready = 1'b1;  w_write = 1'b1;  w_din = bus.wr_data;
        w_stop = w_cnt_one;  w_cnt = r_cnt - CNT_ONE;
      end
      S_RSTA: if (w_ack) begin
        if (w_nack) begin
          w_stop = 1'b1;  w_err = 1'b1;
        end else begin
          w_read = 1'b1;  w_ack_in = w_cnt_one;  w_stop = w_cnt_one;
        end
      end
      S_RD: if (w_ack) begin
        w_rd_valid = 1'b1;  w_rd_data = bus.bc_dout;  w_cnt = r_cnt - CNT_ONE;
        if (w_cnt_one) begin
          w_busy = 1'b0;  w_done = 1'b1;
        end else begin
          w_read = 1'b1;  w_ack_in = w_cnt_two;  w_stop = w_cnt_two;
        end
      end
      S_ABORT: if (w_ack) begin
        w_busy = 1'b0;  w_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.wr_ready  = r_wr_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.bc_start  = r_start;
  assign bus.bc_stop   = r_stop;
  assign bus.bc_read   = r_read;
  assign bus.bc_write  = r_write;
  assign bus.bc_ack_in = r_ack_in;
  assign bus.bc_din    = r_din;

endmodule
